// File: rtl/serv_ibus_rom.sv
// Wishbone-classic instruction ROM for SERV: preloadable word store, programmable
// wait states, out-of-range detection, and a DRAIN state that guarantees one ack per fetch.
module serv_ibus_rom #(
  parameter int          AW          = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] OOB_INSN    = 32'h00000000
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_wb_ibus_adr,
  input  logic          i_wb_ibus_cyc,
  output logic [31:0]   o_wb_ibus_rdt,
  output logic          o_wb_ibus_ack,
  input  logic          i_load_en,
  input  logic [AW-1:0] i_load_adr,
  input  logic [31:0]   i_load_dat,
  output logic          o_oob,
  output logic          o_busy
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_check
    $error("serv_ibus_rom: WAIT_STATES must be in 0..15");
  end

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [29:0]   adr_q;
  logic          capture;
  logic          fetch;
  logic [29:0]   rd_wadr;
  logic [31:0]   rd_word;
  logic          rd_oob;
  logic [31:0]   mem [0:(1<<AW)-1];

  logic unused_adr_lsb;
  assign unused_adr_lsb = ^i_wb_ibus_adr[1:0];

  function automatic logic out_of_range(input logic [29:0] wadr);
    return |wadr[29:AW];
  endfunction

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    fetch   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_wb_ibus_cyc) begin
          capture = 1'b1;
          if (WS == 4'd0) begin
            state_d = S_ACK;
            fetch   = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Abort takes priority over counter expiry.
        if (!i_wb_ibus_cyc) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = S_ACK;
          fetch   = 1'b1;
        end
      end
      S_ACK:   state_d = S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the fetch happens on the capture edge, so read the live address.
  assign rd_wadr = capture ? i_wb_ibus_adr[31:2] : adr_q;
  assign rd_oob  = out_of_range(rd_wadr);
  assign rd_word = rd_oob ? OOB_INSN : mem[rd_wadr[AW-1:0]];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q         <= 4'd0;
      adr_q         <= 30'd0;
      o_wb_ibus_rdt <= 32'h0;
      o_wb_ibus_ack <= 1'b0;
      o_oob         <= 1'b0;
    end else begin
      if (capture) begin
        adr_q <= i_wb_ibus_adr[31:2];
        cnt_q <= WS;
      end else if (state_q == S_WAIT && i_wb_ibus_cyc) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (fetch) o_wb_ibus_rdt <= rd_word;
      o_wb_ibus_ack <= fetch;
      o_oob         <= fetch & rd_oob;
    end
  end

  // Store is not reset; nonblocking write gives read-before-write on a same-edge collision.
  always_ff @(posedge clk) begin
    if (i_load_en) mem[i_load_adr] <= i_load_dat;
  end

  assign o_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_serv_ibus_rom.sv
// Directed bench for serv_ibus_rom: three instances (0, 1 and 4 wait states) share
// the request and preload inputs; each test checks only the instance it targets.
module tb_serv_ibus_rom;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adr;
  logic        cyc;
  logic        load_en;
  logic [7:0]  load_adr;
  logic [31:0] load_dat;

  logic [31:0] rdt0, rdt1, rdt4;
  logic        ack0, ack1, ack4;
  logic        oob0, oob1, oob4;
  logic        busy0, busy1, busy4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serv_ibus_rom #(.AW(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .i_rst_n(rst_n), .i_wb_ibus_adr(adr), .i_wb_ibus_cyc(cyc),
    .o_wb_ibus_rdt(rdt0), .o_wb_ibus_ack(ack0), .i_load_en(load_en),
    .i_load_adr(load_adr), .i_load_dat(load_dat), .o_oob(oob0), .o_busy(busy0));

  serv_ibus_rom #(.AW(8), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .i_rst_n(rst_n), .i_wb_ibus_adr(adr), .i_wb_ibus_cyc(cyc),
    .o_wb_ibus_rdt(rdt1), .o_wb_ibus_ack(ack1), .i_load_en(load_en),
    .i_load_adr(load_adr), .i_load_dat(load_dat), .o_oob(oob1), .o_busy(busy1));

  serv_ibus_rom #(.AW(8), .WAIT_STATES(4)) u_ws4 (
    .clk(clk), .i_rst_n(rst_n), .i_wb_ibus_adr(adr), .i_wb_ibus_cyc(cyc),
    .o_wb_ibus_rdt(rdt4), .o_wb_ibus_ack(ack4), .i_load_en(load_en),
    .i_load_adr(load_adr), .i_load_dat(load_dat), .o_oob(oob4), .o_busy(busy4));

  typedef struct {
    logic [31:0] adr;
    logic [31:0] rdt;
    logic        oob;
  } vec_t;

  vec_t vecs [8];

  function automatic logic ack_of(input int sel);
    case (sel)
      0:       return ack0;
      4:       return ack4;
      default: return ack1;
    endcase
  endfunction

  function automatic logic oob_of(input int sel);
    case (sel)
      0:       return oob0;
      4:       return oob4;
      default: return oob1;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy0;
      4:       return busy4;
      default: return busy1;
    endcase
  endfunction

  function automatic logic [31:0] rdt_of(input int sel);
    case (sel)
      0:       return rdt0;
      4:       return rdt4;
      default: return rdt1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    load_en  = 1'b1;
    load_adr = a;
    load_dat = d;
    tick();
    load_en  = 1'b0;
  endtask

  task automatic settle();
    cyc = 1'b0;
    repeat (12) tick();
  endtask

  // One complete fetch: ack latency, data, oob, single-cycle pulse, return to idle.
  task automatic fetch(input int sel, input logic [31:0] a, input logic [31:0] exp_rdt,
                       input logic exp_oob, input int exp_lat, input string nm);
    int   lat;
    logic got;
    lat = 0;
    got = 1'b0;
    adr = a;
    cyc = 1'b1;
    for (int k = 0; k < 24 && !got; k++) begin
      tick();
      if (ack_of(sel)) got = 1'b1;
      else             lat++;
    end
    chk($sformatf("%s ack_seen", nm), 32'(got), 32'd1);
    if (got) begin
      chk($sformatf("%s latency", nm), 32'(lat), 32'(exp_lat));
      chk($sformatf("%s rdt", nm), rdt_of(sel), exp_rdt);
      chk($sformatf("%s oob", nm), 32'(oob_of(sel)), 32'(exp_oob));
    end
    cyc = 1'b0;
    tick();
    chk($sformatf("%s ack_pulse", nm), 32'({ack_of(sel), oob_of(sel)}), 32'd0);
    tick();
    chk($sformatf("%s busy_off", nm), 32'(busy_of(sel)), 32'd0);
  endtask

  initial begin
    logic [8:0]  pat;
    logic [31:0] held;
    logic        seen;

    rst_n    = 1'b1;
    cyc      = 1'b0;
    adr      = 32'h0;
    load_en  = 1'b0;
    load_adr = 8'h0;
    load_dat = 32'h0;

    vecs[0] = '{32'h0000_000C, 32'h0050_0093, 1'b0};
    vecs[1] = '{32'h0000_000F, 32'h0050_0093, 1'b0};
    vecs[2] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
    vecs[3] = '{32'h0000_0004, 32'h0010_0093, 1'b0};
    vecs[4] = '{32'h0000_03FC, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h8000_0008, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h0000_0008, 32'h0020_0113, 1'b0};

    // Asynchronous reset asserted mid-cycle
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset ack", 32'(ack1), 32'd0);
    chk("reset oob", 32'(oob1), 32'd0);
    chk("reset busy", 32'(busy1), 32'd0);
    chk("reset rdt", rdt1, 32'h0);
    chk("reset rdt ws4", rdt4, 32'h0);
    tick();
    rst_n = 1'b1;

    load(8'd0,   32'h0000_0013);
    load(8'd1,   32'h0010_0093);
    load(8'd2,   32'h0020_0113);
    load(8'd3,   32'h0050_0093);
    load(8'd5,   32'h1111_1111);
    load(8'd6,   32'h6666_6666);
    load(8'd255, 32'hDEAD_BEEF);

    for (int i = 0; i < 8; i++)
      fetch(1, vecs[i].adr, vecs[i].rdt, vecs[i].oob, 1, $sformatf("ws1 vec%0d", i));

    // Zero wait states, words 0..3 in order
    settle();
    fetch(0, 32'h00, 32'h0000_0013, 1'b0, 0, "ws0 w0");
    fetch(0, 32'h04, 32'h0010_0093, 1'b0, 0, "ws0 w1");
    fetch(0, 32'h08, 32'h0020_0113, 1'b0, 0, "ws0 w2");
    fetch(0, 32'h0C, 32'h0050_0093, 1'b0, 0, "ws0 w3");

    // Zero wait states with cyc held: acks every third cycle
    settle();
    pat = 9'd0;
    adr = 32'h04;
    cyc = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      pat[i] = ack0;
    end
    cyc = 1'b0;
    chk("ws0 held spacing", 32'(pat), 32'(9'b001001001));

    // Abort after two cycles in WAIT (4 wait states)
    settle();
    held = rdt4;
    seen = 1'b0;
    adr  = 32'h04;
    cyc  = 1'b1;
    repeat (3) begin
      tick();
      seen |= ack4;
    end
    cyc = 1'b0;
    repeat (8) begin
      tick();
      seen |= ack4;
    end
    chk("ws4 abort no_ack", 32'(seen), 32'd0);
    chk("ws4 abort busy", 32'(busy4), 32'd0);
    chk("ws4 abort rdt", rdt4, held);
    fetch(4, 32'h04, 32'h0010_0093, 1'b0, 4, "ws4 after_abort");

    // Abort on the same edge the counter would expire (1 wait state)
    settle();
    held = rdt1;
    seen = 1'b0;
    adr  = 32'h08;
    cyc  = 1'b1;
    tick();
    cyc = 1'b0;
    repeat (4) begin
      tick();
      seen |= ack1;
    end
    chk("ws1 abort_at_expiry no_ack", 32'(seen), 32'd0);
    chk("ws1 abort_at_expiry rdt", rdt1, held);

    // Preload during WAIT wins; address change after capture is ignored
    settle();
    adr = 32'h18;
    cyc = 1'b1;
    tick();
    adr = 32'h00;
    load(8'd6, 32'h7777_7777);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      seen = ack4;
    end
    chk("ws4 wait_preload ack", 32'(seen), 32'd1);
    chk("ws4 wait_preload rdt", rdt4, 32'h7777_7777);
    cyc = 1'b0;

    // Preload on the ACK-entry edge: old word returned, new word on the next fetch
    settle();
    adr = 32'h14;
    cyc = 1'b1;
    tick();
    load(8'd5, 32'h2222_2222);
    chk("ws1 collide ack", 32'(ack1), 32'd1);
    chk("ws1 collide rdt", rdt1, 32'h1111_1111);
    cyc = 1'b0;
    tick();
    tick();
    fetch(1, 32'h14, 32'h2222_2222, 1'b0, 1, "ws1 after_collide");

    // Reset during ACK drops ack at once; no ack after release without a new request
    settle();
    adr = 32'h0C;
    cyc = 1'b1;
    repeat (2) tick();
    chk("ws1 pre_reset ack", 32'(ack1), 32'd1);
    cyc = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ws1 reset_in_ack ack", 32'(ack1), 32'd0);
    chk("ws1 reset_in_ack busy", 32'(busy1), 32'd0);
    chk("ws1 reset_in_ack rdt", rdt1, 32'h0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen |= ack1;
    end
    chk("ws1 post_reset no_ack", 32'(seen), 32'd0);
    fetch(1, 32'h0C, 32'h0050_0093, 1'b0, 1, "ws1 post_reset fetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
